// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result and flags.
// Single-cycle logic, shift and add/sub operations are written on the accept edge.
// MUL/MULH use an iterative shift-add multiplier that processes one multiplier bit per cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   in_a     operand A
//   in_b     operand B; also the shift amount
//   control  4-bit opcode
//   execute  issue request, accepted when execute && ready
//   ready    block can accept an opcode (low while multiplying)
//   done     one-cycle pulse when out/flags hold a new result
//   out      registered result
//   zf       zero flag
//   cf       carry/borrow flag
//   nf       negative flag (MSB of the result)
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       control,
  input  logic             execute,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zf,
  output logic             cf,
  output logic             nf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpNand = 4'b0000;
  localparam logic [3:0] OpAnd  = 4'b0001;
  localparam logic [3:0] OpXor  = 4'b0010;
  localparam logic [3:0] OpShr  = 4'b0011;
  localparam logic [3:0] OpPass = 4'b0100;
  localparam logic [3:0] OpOr   = 4'b0101;
  localparam logic [3:0] OpAdd  = 4'b0110;
  localparam logic [3:0] OpSub  = 4'b0111;
  localparam logic [3:0] OpAdc  = 4'b1000;
  localparam logic [3:0] OpSbc  = 4'b1001;
  localparam logic [3:0] OpShl  = 4'b1010;
  localparam logic [3:0] OpCmp  = 4'b1011;
  localparam logic [3:0] OpMul  = 4'b1100;
  localparam logic [3:0] OpMulh = 4'b1101;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               mulh_q, mulh_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zf_q, zf_d;
  logic               cf_q, cf_d;
  logic               nf_q, nf_d;
  logic               done_q, done_d;

  logic               carry_in;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   res;
  logic               wr_res;

  // ADC/SBC fold in the carry registered before the accept edge.
  assign carry_in = ((control == OpAdc) || (control == OpSbc)) && cf_q;
  assign sum      = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};
  // Bit WIDTH of the difference is the borrow (unsigned a < b + cin).
  assign diff     = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, carry_in};
  assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mulh_d   = mulh_q;
    out_d    = out_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    nf_d     = nf_q;
    done_d   = 1'b0;
    res      = out_q;
    wr_res   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (execute) begin
          done_d = 1'b1;
          wr_res = 1'b1;
          case (control)
            OpNand: res = ~(in_a & in_b);
            OpAnd:  res = in_a & in_b;
            OpXor:  res = in_a ^ in_b;
            OpOr:   res = in_a | in_b;
            // A shift by WIDTH or more naturally yields zero.
            OpShr:  res = in_a >> in_b;
            OpShl:  res = in_a << in_b;
            OpPass: res = in_a;
            OpAdd, OpAdc: begin
              res  = sum[WIDTH-1:0];
              cf_d = sum[WIDTH];
            end
            OpSub, OpSbc: begin
              res  = diff[WIDTH-1:0];
              cf_d = diff[WIDTH];
            end
            OpCmp: begin
              wr_res = 1'b0;
              zf_d   = (diff[WIDTH-1:0] == '0);
              nf_d   = diff[WIDTH-1];
              cf_d   = diff[WIDTH];
            end
            OpMul, OpMulh: begin
              wr_res   = 1'b0;
              done_d   = 1'b0;
              state_d  = StBusy;
              mcand_d  = {{WIDTH{1'b0}}, in_a};
              mplier_d = in_b;
              acc_d    = '0;
              count_d  = '0;
              mulh_d   = control[0];
            end
            // Reserved opcodes leave result and flags alone but still acknowledge.
            default: wr_res = 1'b0;
          endcase
        end
      end
      StBusy: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          wr_res  = 1'b1;
          if (mulh_q) begin
            res  = acc_nx[2*WIDTH-1:WIDTH];
            cf_d = |acc_nx[WIDTH-1:0];
          end else begin
            res  = acc_nx[WIDTH-1:0];
            cf_d = |acc_nx[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_res) begin
      out_d = res;
      zf_d  = (res == '0);
      nf_d  = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mulh_q   <= 1'b0;
      out_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      nf_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mulh_q   <= mulh_d;
      out_q    <= out_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      nf_q     <= nf_d;
      done_q   <= done_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = done_q;
  assign out   = out_q;
  assign zf    = zf_q;
  assign cf    = cf_q;
  assign nf    = nf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at WIDTH=8.
// Expected values are hand-computed constants.
module tb_alu_seq;

  localparam int unsigned WIDTH = 8;

  localparam logic [3:0] OpPass = 4'b0100;
  localparam logic [3:0] OpAdd  = 4'b0110;
  localparam logic [3:0] OpSub  = 4'b0111;
  localparam logic [3:0] OpAdc  = 4'b1000;
  localparam logic [3:0] OpSbc  = 4'b1001;
  localparam logic [3:0] OpShr  = 4'b0011;
  localparam logic [3:0] OpShl  = 4'b1010;
  localparam logic [3:0] OpCmp  = 4'b1011;
  localparam logic [3:0] OpMul  = 4'b1100;
  localparam logic [3:0] OpMulh = 4'b1101;
  localparam logic [3:0] OpRsvd = 4'b1110;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       control;
  logic             execute;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zf;
  logic             cf;
  logic             nf;

  int n_vectors;
  int n_miscompares;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_a    (in_a),
    .in_b    (in_b),
    .control (control),
    .execute (execute),
    .ready   (ready),
    .done    (done),
    .out     (out),
    .zf      (zf),
    .cf      (cf),
    .nf      (nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one op at the falling edge; return 1 time unit after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    control = op;
    in_a    = a;
    in_b    = b;
    execute = 1'b1;
    @(posedge clk);
    #1;
    execute = 1'b0;
  endtask

  // Count edges until done rises, bounded so a hung multiplier still reaches the summary.
  task automatic wait_done(output int cycles, output logic [7:0] out_mid);
    cycles  = 0;
    out_mid = 8'hxx;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 4) out_mid = out;
    end
  endtask

  initial begin
    int          cyc;
    logic [7:0]  mid;
    logic        saw_done;

    n_vectors     = 0;
    n_miscompares = 0;
    rst_n   = 1'b0;
    in_a    = '0;
    in_b    = '0;
    control = '0;
    execute = 1'b0;

    #12;
    check("rst_out",   out,   8'h00);
    check("rst_zf",    zf,    1'b0);
    check("rst_cf",    cf,    1'b0);
    check("rst_nf",    nf,    1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_done",  done,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OpAdd, 8'hF0, 8'h20);
    check("add1_out",  out,  8'h10);
    check("add1_cf",   cf,   1'b1);
    check("add1_zf",   zf,   1'b0);
    check("add1_done", done, 1'b1);
    @(posedge clk);
    #1;
    check("add1_done_drop", done, 1'b0);

    issue(OpAdd, 8'hFF, 8'h01);
    check("add2_out", out, 8'h00);
    check("add2_zf",  zf,  1'b1);
    check("add2_cf",  cf,  1'b1);
    issue(OpAdc, 8'h00, 8'h00);
    check("adc_out",  out,  8'h01);
    check("adc_cf",   cf,   1'b0);
    check("adc_zf",   zf,   1'b0);
    check("adc_done", done, 1'b1);

    issue(OpSub, 8'h03, 8'h05);
    check("sub_out", out, 8'hFE);
    check("sub_cf",  cf,  1'b1);
    check("sub_nf",  nf,  1'b1);
    issue(OpSbc, 8'h10, 8'h00);
    check("sbc_out", out, 8'h0F);
    check("sbc_cf",  cf,  1'b0);

    issue(OpPass, 8'h42, 8'h00);
    check("pass_out", out, 8'h42);
    issue(OpCmp, 8'h05, 8'h05);
    check("cmp_out",  out,  8'h42);
    check("cmp_zf",   zf,   1'b1);
    check("cmp_cf",   cf,   1'b0);
    check("cmp_nf",   nf,   1'b0);
    check("cmp_done", done, 1'b1);

    // Set cf=1 so the shifts can show it is preserved.
    issue(OpSub, 8'h03, 8'h05);
    issue(OpShr, 8'h80, 8'd9);
    check("shr_out", out, 8'h00);
    check("shr_zf",  zf,  1'b1);
    check("shr_cf",  cf,  1'b1);
    issue(OpShl, 8'h01, 8'd7);
    check("shl_out", out, 8'h80);
    check("shl_nf",  nf,  1'b1);
    check("shl_cf",  cf,  1'b1);

    issue(OpMul, 8'd13, 8'd11);
    check("mul1_ready_low", ready, 1'b0);
    check("mul1_no_done",   done,  1'b0);
    wait_done(cyc, mid);
    check("mul1_latency",  cyc,   8);
    check("mul1_out_hold", mid,   8'h80);
    check("mul1_out",      out,   8'h8F);
    check("mul1_cf",       cf,    1'b0);
    check("mul1_ready",    ready, 1'b1);
    @(posedge clk);
    #1;
    check("mul1_done_drop", done, 1'b0);

    issue(OpMul, 8'hFF, 8'hFF);
    wait_done(cyc, mid);
    check("mul2_out", out, 8'h01);
    check("mul2_cf",  cf,  1'b1);

    issue(OpMulh, 8'hFF, 8'hFF);
    wait_done(cyc, mid);
    check("mulh_out", out, 8'hFE);
    check("mulh_cf",  cf,  1'b1);
    check("mulh_nf",  nf,  1'b1);

    // Disturb inputs and pulse execute while busy.
    issue(OpMul, 8'd13, 8'd11);
    @(negedge clk);
    execute = 1'b1;
    in_a    = 8'hFF;
    in_b    = 8'h77;
    control = OpAdd;
    @(negedge clk);
    execute = 1'b0;
    wait_done(cyc, mid);
    check("mul3_out", out, 8'h8F);
    check("mul3_cf",  cf,  1'b0);

    // Abort a multiply after four processed bits.
    issue(OpMul, 8'd13, 8'd11);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out",   out,   8'h00);
    check("abort_cf",    cf,    1'b0);
    check("abort_zf",    zf,    1'b0);
    check("abort_nf",    nf,    1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_done",  done,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);
    issue(OpAdd, 8'h01, 8'h02);
    check("post_add_out",  out,  8'h03);
    check("post_add_done", done, 1'b1);

    issue(OpRsvd, 8'hAA, 8'h55);
    check("rsvd_out",  out,  8'h03);
    check("rsvd_done", done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
